csum_arbiter: RTL and testbench

CSUM_ARBITER -- requirements
Module: csum_arbiter

---
 rtl/csum_arbiter.sv | 130 +++++++++++++
 tb/tb_csum_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csum_arbiter.sv
// Two-requester round-robin arbiter that time-shares one complex half-sum datapath
// ((A+B)>>>1 per component) into a single registered, back-pressurable result slot.
module csum_arbiter #(
    parameter int DataWidth = 16,
    parameter int TagWidth  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        req0_valid,
    output logic                        req0_ready,
    input  logic signed [DataWidth-1:0] req0_re1,
    input  logic signed [DataWidth-1:0] req0_im1,
    input  logic signed [DataWidth-1:0] req0_re2,
    input  logic signed [DataWidth-1:0] req0_im2,
    input  logic        [TagWidth-1:0]  req0_tag,

    input  logic                        req1_valid,
    output logic                        req1_ready,
    input  logic signed [DataWidth-1:0] req1_re1,
    input  logic signed [DataWidth-1:0] req1_im1,
    input  logic signed [DataWidth-1:0] req1_re2,
    input  logic signed [DataWidth-1:0] req1_im2,
    input  logic        [TagWidth-1:0]  req1_tag,

    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [DataWidth-1:0] out_re,
    output logic signed [DataWidth-1:0] out_im,
    output logic                        out_src,
    output logic        [TagWidth-1:0]  out_tag,

    output logic                        dbg_state
);

    // Handshake: a transfer on any port happens in a cycle where valid and ready are
    // both 1 at the rising edge; valid never waits on ready, ready may depend on valid.

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    logic   last_grant;
    logic   [15:0] grant_cnt0;
    logic   [15:0] grant_cnt1;

    logic accept;
    logic grant;
    logic winner;

    logic signed [DataWidth-1:0] sel_re1;
    logic signed [DataWidth-1:0] sel_im1;
    logic signed [DataWidth-1:0] sel_re2;
    logic signed [DataWidth-1:0] sel_im2;
    logic        [TagWidth-1:0]  sel_tag;
    logic        [DataWidth:0]   sum_re;
    logic        [DataWidth:0]   sum_im;

    // The slot can take a new result when empty or when it drains this same cycle.
    // Gating with rst_n keeps both readies low while reset is held.
    always_comb begin
        accept = (state == EMPTY) || out_ready;
        grant  = rst_n && accept && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) begin
            winner = ~last_grant;
        end else begin
            winner = req1_valid;
        end
    end

    assign req0_ready = grant & ~winner;
    assign req1_ready = grant &  winner;

    always_comb begin
        if (winner) begin
            sel_re1 = req1_re1;
            sel_im1 = req1_im1;
            sel_re2 = req1_re2;
            sel_im2 = req1_im2;
            sel_tag = req1_tag;
        end else begin
            sel_re1 = req0_re1;
            sel_im1 = req0_im1;
            sel_re2 = req0_re2;
            sel_im2 = req0_im2;
            sel_tag = req0_tag;
        end
    end

    // One extra bit of headroom, then drop the LSB: floor((a+b)/2) that can never overflow.
    always_comb begin
        sum_re = {sel_re1[DataWidth-1], sel_re1} + {sel_re2[DataWidth-1], sel_re2};
        sum_im = {sel_im1[DataWidth-1], sel_im1} + {sel_im2[DataWidth-1], sel_im2};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            last_grant <= 1'b1;
            out_re     <= '0;
            out_im     <= '0;
            out_src    <= 1'b0;
            out_tag    <= '0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (grant) begin
            state      <= FULL;
            last_grant <= winner;
            out_re     <= sum_re[DataWidth:1];
            out_im     <= sum_im[DataWidth:1];
            out_src    <= winner;
            out_tag    <= sel_tag;
            if (!winner && grant_cnt0 != 16'hFFFF) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (winner && grant_cnt1 != 16'hFFFF) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
        end else if (out_ready) begin
            // Drain without refill; result fields stay as they were.
            state <= EMPTY;
        end
    end

    assign out_valid = (state == FULL);
    assign dbg_state = state;

endmodule

// File: tb/tb_csum_arbiter.sv
// Bench for csum_arbiter: directed vectors plus a cycle-level behavioural model
// (slot occupancy, round-robin pointer, floor half-sums) checked on every falling edge.
module tb_csum_arbiter;
    localparam int W = 16;
    localparam int T = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                req0_valid, req0_ready;
    logic signed [W-1:0] req0_re1, req0_im1, req0_re2, req0_im2;
    logic        [T-1:0] req0_tag;
    logic                req1_valid, req1_ready;
    logic signed [W-1:0] req1_re1, req1_im1, req1_re2, req1_im2;
    logic        [T-1:0] req1_tag;
    logic                out_valid, out_ready, out_src;
    logic signed [W-1:0] out_re, out_im;
    logic        [T-1:0] out_tag;
    logic                dbg_state;

    csum_arbiter #(.DataWidth(W), .TagWidth(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_re1(req0_re1), .req0_im1(req0_im1), .req0_re2(req0_re2), .req0_im2(req0_im2),
        .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_re1(req1_re1), .req1_im1(req1_im1), .req1_re2(req1_re2), .req1_im2(req1_im2),
        .req1_tag(req1_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_src(out_src), .out_tag(out_tag),
        .dbg_state(dbg_state)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // floor((a+b)/2) by plain integer arithmetic, truncated to the result width
    function automatic logic [W-1:0] half(input int a, input int b);
        int s;
        int q;
        s = a + b;
        if (s < 0 && (s % 2) != 0) q = (s - 1) / 2;
        else q = s / 2;
        return q[W-1:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int n, input bit v, input int a_re, input int a_im,
                         input int b_re, input int b_im, input int tag);
        if (n == 0) begin
            req0_valid = v;
            req0_re1 = 16'(a_re); req0_im1 = 16'(a_im);
            req0_re2 = 16'(b_re); req0_im2 = 16'(b_im);
            req0_tag = 4'(tag);
        end else begin
            req1_valid = v;
            req1_re1 = 16'(a_re); req1_im1 = 16'(a_im);
            req1_re2 = 16'(b_re); req1_im2 = 16'(b_im);
            req1_tag = 4'(tag);
        end
    endtask

    task automatic expect_out(input string name, input int re, input int im,
                              input int src, input int tag);
        chk({name, "_valid"}, 16'(out_valid), 16'd1);
        chk({name, "_re"},    out_re,         16'(re));
        chk({name, "_im"},    out_im,         16'(im));
        chk({name, "_src"},   16'(out_src),   16'(src));
        chk({name, "_tag"},   16'(out_tag),   16'(tag));
    endtask

    // ---------------- scoreboard: behavioural model ----------------
    bit           m_valid, m_src, m_last, m_g, m_w;
    logic [W-1:0] m_re, m_im;
    logic [T-1:0] m_tag;
    int           m_c0, m_c1;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_valid = 0; m_src = 0; m_last = 1; m_re = '0; m_im = '0; m_tag = '0;
            m_c0 = 0; m_c1 = 0;
            chk("rst_out_valid", 16'(out_valid), 16'd0);
            chk("rst_out_re",    out_re,         16'd0);
            chk("rst_out_im",    out_im,         16'd0);
            chk("rst_out_src",   16'(out_src),   16'd0);
            chk("rst_out_tag",   16'(out_tag),   16'd0);
            chk("rst_ready0",    16'(req0_ready), 16'd0);
            chk("rst_ready1",    16'(req1_ready), 16'd0);
            chk("rst_cnt0",      dut.grant_cnt0, 16'd0);
            chk("rst_cnt1",      dut.grant_cnt1, 16'd0);
        end else begin
            chk("m_out_valid", 16'(out_valid), 16'(m_valid));
            chk("m_out_re",    out_re,         m_re);
            chk("m_out_im",    out_im,         m_im);
            chk("m_out_src",   16'(out_src),   16'(m_src));
            chk("m_out_tag",   16'(out_tag),   16'(m_tag));
            chk("m_cnt0",      dut.grant_cnt0, 16'(m_c0));
            chk("m_cnt1",      dut.grant_cnt1, 16'(m_c1));
            m_g = (!m_valid || out_ready) && (req0_valid || req1_valid);
            m_w = (req0_valid && req1_valid) ? !m_last : req1_valid;
            chk("m_ready0", 16'(req0_ready), 16'(m_g && !m_w));
            chk("m_ready1", 16'(req1_ready), 16'(m_g && m_w));
            if (m_g) begin
                m_valid = 1;
                m_src   = m_w;
                m_last  = m_w;
                if (!m_w) begin
                    m_re  = half(int'(req0_re1), int'(req0_re2));
                    m_im  = half(int'(req0_im1), int'(req0_im2));
                    m_tag = req0_tag;
                    if (m_c0 < 65535) m_c0++;
                end else begin
                    m_re  = half(int'(req1_re1), int'(req1_re2));
                    m_im  = half(int'(req1_im1), int'(req1_im2));
                    m_tag = req1_tag;
                    if (m_c1 < 65535) m_c1++;
                end
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    bit pat_v0 [8] = '{0, 1, 1, 1, 0, 0, 1, 0};
    bit pat_v1 [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    bit pat_rdy[8] = '{1, 0, 0, 1, 0, 1, 1, 1};

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        out_ready = 0;
        #1;
        chk("init_out_valid", 16'(out_valid), 16'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // single request from requester 0
        drive(0, 1, 100, -50, 300, 10, 3);
        out_ready = 1;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("single", 200, -20, 0, 3);
        tick();
        chk("single_drain", 16'(out_valid), 16'd0);

        // extremes
        drive(1, 1, 32767, -32768, 32767, -32768, 5);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_out("ext_max", 32767, -32768, 1, 5);
        drive(0, 1, -1, 1, 0, 0, 7);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("ext_neg", -1, 0, 0, 7);
        tick();

        // mixed valid / backpressure patterns, checked by the model
        for (int i = 0; i < 8; i++) begin
            drive(0, pat_v0[i], i * 100, -i * 37, 50 - i, i * 3, i);
            drive(1, pat_v1[i], -i * 200, i * 11, 7 * i, -5, 8 + i);
            out_ready = pat_rdy[i];
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        out_ready = 1;
        tick();

        // contention after a fresh reset: 0,1,0,1,...
        rst_n = 0;
        tick();
        rst_n = 1;
        drive(0, 1, 10, 20, 30, 40, 1);
        drive(1, 1, -7, -9, 5, 3, 2);
        out_ready = 1;
        for (int i = 0; i < 8; i++) exp_q.push_back(16'(i % 2));
        for (int i = 0; i < 8; i++) begin
            int d;
            tick();
            chk("rr_valid", 16'(out_valid), 16'd1);
            chk("rr_src", 16'(out_src), exp_q.pop_front());
            d = int'(dut.grant_cnt0) - int'(dut.grant_cnt1);
            chk("rr_balance", 16'(d >= -1 && d <= 1), 16'd1);
        end

        // backpressure: requester 1's result must hold for 5 cycles
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out("hold", -1, -3, 1, 2);
            chk("hold_ready0", 16'(req0_ready), 16'd0);
            chk("hold_ready1", 16'(req1_ready), 16'd0);
        end
        out_ready = 1;
        #1;
        chk("release_ready0", 16'(req0_ready), 16'd1);
        chk("release_ready1", 16'(req1_ready), 16'd0);
        tick();
        expect_out("no_bubble", 20, 30, 0, 1);

        // asynchronous reset while FULL
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("async_valid", 16'(out_valid), 16'd0);
        chk("async_ready0", 16'(req0_ready), 16'd0);
        chk("async_ready1", 16'(req1_ready), 16'd0);
        chk("async_re", out_re, 16'd0);
        @(posedge clk);
        #1 rst_n = 1;
        #1;
        chk("post_rst_ready0", 16'(req0_ready), 16'd1);
        chk("post_rst_ready1", 16'(req1_ready), 16'd0);
        @(posedge clk);
        #1;
        expect_out("post_rst", 20, 30, 0, 1);

        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
